rr_encoder4x2: RTL

- Sequential 4-to-2 encoder: the inverse of the 2x4 decoder. It accepts four request lines and returns the 2-bit index (a,b pair) of one request.
- Requests are sticky. They are held in a pending register until encoded and handed off through a valid/ready handshake.
- Arbitration between simultaneous requests is round-robin, or fixed priority when configured.
- Sits between decoded one-hot event lines and any consumer needing a binary index.

---
 rtl/rr_encoder4x2.sv | 107 ++++++++++
 1 files changed

// File: rtl/rr_encoder4x2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_encoder4x2
//  Purpose  : Sticky 4-to-2 request encoder with round-robin or fixed-priority
//             arbitration and a valid/ready grant handoff.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_encoder4x2 #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] code,
    output logic       valid,
    input  logic       ready,
    output logic       multi,
    output logic [3:0] pending
);

    localparam logic c_IDLE = 1'b0;
    localparam logic c_HOLD = 1'b1;

    logic       r_state;
    logic [3:0] r_pending;
    logic [1:0] r_code;
    logic       r_valid;
    logic       r_multi;

    logic [3:0] w_cand;
    logic [1:0] w_sel;
    logic       w_load;
    logic       w_multi;
    logic [3:0] w_grant_mask;

    assign w_cand       = r_pending | req;
    assign w_load       = (w_cand != 4'd0) && ((r_state == c_IDLE) || ready);
    assign w_multi      = |(w_cand & (w_cand - 4'd1));
    assign w_grant_mask = 4'b0001 << w_sel;

    generate
        if (ROUND_ROBIN != 0) begin : g_rr
            logic [1:0] r_ptr;
            logic [7:0] w_dbl;
            logic [3:0] w_rot;
            logic [1:0] w_off;

            // Rotate the candidates so bit 0 is the pointer position, then take the first set bit.
            always_comb begin
                w_dbl = {w_cand, w_cand};
                w_rot = w_dbl[r_ptr +: 4];
                if (w_rot[0])      w_off = 2'd0;
                else if (w_rot[1]) w_off = 2'd1;
                else if (w_rot[2]) w_off = 2'd2;
                else               w_off = 2'd3;
                w_sel = r_ptr + w_off;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ptr <= 2'd0;
                end else if (w_load) begin
                    r_ptr <= w_sel + 2'd1;
                end
            end
        end else begin : g_fp
            always_comb begin
                if (w_cand[3])      w_sel = 2'd3;
                else if (w_cand[2]) w_sel = 2'd2;
                else if (w_cand[1]) w_sel = 2'd1;
                else                w_sel = 2'd0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_pending <= 4'd0;
            r_code    <= 2'd0;
            r_valid   <= 1'b0;
            r_multi   <= 1'b0;
        end else if (w_load) begin
            r_code    <= w_sel;
            r_valid   <= 1'b1;
            r_multi   <= w_multi;
            r_pending <= w_cand & ~w_grant_mask;
            r_state   <= c_HOLD;
        end else if (r_state == c_IDLE) begin
            r_pending <= 4'd0;
        end else if (ready) begin
            // Grant consumed with nothing left: code and multi keep their last values.
            r_valid   <= 1'b0;
            r_pending <= 4'd0;
            r_state   <= c_IDLE;
        end else begin
            r_pending <= w_cand;
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign multi   = r_multi;
    assign pending = r_pending;

endmodule
`default_nettype wire
